// File: rtl/stack_sequencer.sv
// Operand-stack sequencer: accepts single-cycle push/pop/tos pulses, runs each
// through a small FSM and reports completion with a one-cycle done/err pulse.
module stack_sequencer #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              tos,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              ready,
   output logic              done,
   output logic              err,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      FIN  = 2'd3
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

   state_t            state_r;
   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [DATA_W-1:0] din_r;
   logic              is_pop_r;
   logic [1:0]        req_cnt_s;
   logic [ADDR_W-1:0] wr_addr_s;
   logic [ADDR_W-1:0] rd_addr_s;
   logic [ADDR_W:0]   count_dec_s;

   // Request decode and stack addressing derived from the current count.
   always_comb begin
      req_cnt_s   = {1'b0, push} + {1'b0, pop} + {1'b0, tos};
      count_dec_s = count - ONE_C;
      wr_addr_s   = count[ADDR_W-1:0];
      rd_addr_s   = count_dec_s[ADDR_W-1:0];
   end

   // Storage write; deliberately not reset and suppressed when a reset aborts WR.
   always_ff @(posedge clk) begin
      if (!rst && (state_r == WR) && !full) begin
         mem_r[wr_addr_s] <= din_r;
      end
   end

   // Sequencer FSM with all status outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         count    <= '0;
         dout     <= '0;
         err      <= 1'b0;
         done     <= 1'b0;
         ready    <= 1'b1;
         empty    <= 1'b1;
         full     <= 1'b0;
         din_r    <= '0;
         is_pop_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               err  <= 1'b0;
               if (req_cnt_s == 2'd1) begin
                  din_r    <= din;
                  is_pop_r <= pop;
                  ready    <= 1'b0;
                  state_r  <= push ? WR : RD;
               end else if (req_cnt_s > 2'd1) begin
                  // Illegal combination: report straight away, nothing changes.
                  err     <= 1'b1;
                  done    <= 1'b1;
                  ready   <= 1'b0;
                  state_r <= FIN;
               end else begin
                  ready   <= 1'b1;
                  state_r <= IDLE;
               end
            end
            WR: begin
               if (full) begin
                  err <= 1'b1;
               end else begin
                  err   <= 1'b0;
                  count <= count + ONE_C;
                  empty <= 1'b0;
                  full  <= ((count + ONE_C) == DEPTH_C);
               end
               done    <= 1'b1;
               state_r <= FIN;
            end
            RD: begin
               if (empty) begin
                  err <= 1'b1;
               end else begin
                  err  <= 1'b0;
                  dout <= mem_r[rd_addr_s];
                  if (is_pop_r) begin
                     count <= count_dec_s;
                     full  <= 1'b0;
                     empty <= (count == ONE_C);
                  end
               end
               done    <= 1'b1;
               state_r <= FIN;
            end
            FIN: begin
               done    <= 1'b0;
               err     <= 1'b0;
               ready   <= 1'b1;
               state_r <= IDLE;
            end
            default: begin
               done    <= 1'b0;
               err     <= 1'b0;
               ready   <= 1'b1;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
